// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and the
// load/store path; one outstanding transaction, data-first with a bounded streak.
module mem_port_arbiter #(
   parameter int MAX_DM_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,

   input  logic        dm_req_valid,
   input  logic        dm_req_write,
   input  logic [31:0] dm_req_addr,
   input  logic [31:0] dm_req_wdata,
   input  logic [3:0]  dm_req_wmask,
   output logic        dm_req_ready,
   output logic        dm_resp_valid,
   output logic [31:0] dm_resp_data,

   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_write,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);

   // state   | meaning
   // IDLE    | may issue a request to memory
   // WAIT_IF | fetch outstanding, waiting for mem_resp_valid
   // WAIT_DM | data request outstanding, waiting for mem_resp_valid
   typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

   state_t     state;
   logic [3:0] streak;
   logic       lock_valid;
   logic       lock_dm;
   logic       pend_write;

   logic       grant_dm;
   logic       grant_valid;
   logic       accept;

   // A stalled handshake freezes the owner so the memory never sees a switch.
   always_comb begin
      grant_dm = 1'b0;
      if (lock_valid)
         grant_dm = lock_dm;
      else if (dm_req_valid && !(streak == STREAK_MAX && if_req_valid))
         grant_dm = 1'b1;
   end

   assign grant_valid   = (state == IDLE) && (grant_dm ? dm_req_valid : if_req_valid);
   assign accept        = grant_valid && mem_req_ready;

   assign mem_req_valid = grant_valid;
   assign mem_req_write = grant_dm ? dm_req_write : 1'b0;
   assign mem_req_addr  = grant_dm ? dm_req_addr  : if_req_addr;
   assign mem_req_wdata = grant_dm ? dm_req_wdata : 32'h0;
   assign mem_req_wmask = grant_dm ? dm_req_wmask : 4'h0;

   assign if_req_ready  = grant_valid && !grant_dm && mem_req_ready;
   assign dm_req_ready  = grant_valid &&  grant_dm && mem_req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         streak        <= 4'd0;
         lock_valid    <= 1'b0;
         lock_dm       <= 1'b0;
         pend_write    <= 1'b0;
         if_resp_valid <= 1'b0;
         dm_resp_valid <= 1'b0;
         if_resp_data  <= 32'h0;
         dm_resp_data  <= 32'h0;
      end else begin
         if_resp_valid <= 1'b0;
         dm_resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  lock_valid <= 1'b0;
                  pend_write <= grant_dm && dm_req_write;
                  if (grant_dm) begin
                     state  <= WAIT_DM;
                     streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
                  end else begin
                     state  <= WAIT_IF;
                     streak <= 4'd0;
                  end
               end else if (grant_valid) begin
                  lock_valid <= 1'b1;
                  lock_dm    <= grant_dm;
               end
            end
            WAIT_IF: begin
               if (mem_resp_valid) begin
                  if_resp_data  <= mem_resp_data;
                  if_resp_valid <= 1'b1;
                  state         <= IDLE;
               end
            end
            WAIT_DM: begin
               if (mem_resp_valid) begin
                  dm_resp_data  <= pend_write ? 32'h0 : mem_resp_data;
                  dm_resp_valid <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: store ack, fetch, priority/starvation,
// grant lock, reset mid-transaction and spurious responses.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_req_ready;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        dm_req_valid;
   logic        dm_req_write;
   logic [31:0] dm_req_addr;
   logic [31:0] dm_req_wdata;
   logic [3:0]  dm_req_wmask;
   logic        dm_req_ready;
   logic        dm_resp_valid;
   logic [31:0] dm_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_write;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int vectors = 0;
   int miscompares = 0;

   mem_port_arbiter #(.MAX_DM_STREAK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .dm_req_valid(dm_req_valid), .dm_req_write(dm_req_write), .dm_req_addr(dm_req_addr),
      .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask), .dm_req_ready(dm_req_ready),
      .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Grant order for both requesters continuously valid, MAX_DM_STREAK=4.
   logic [9:0] exp_dm_order = 10'b01111_01111;

   initial begin
      rst_n = 1'b0;
      if_req_valid = 1'b0; if_req_addr = 32'h0;
      dm_req_valid = 1'b0; dm_req_write = 1'b0; dm_req_addr = 32'h0;
      dm_req_wdata = 32'h0; dm_req_wmask = 4'h0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
      #23;
      chk("rst_if_resp_valid", {31'h0, if_resp_valid}, 32'h0);
      chk("rst_dm_resp_valid", {31'h0, dm_resp_valid}, 32'h0);
      chk("rst_if_resp_data", if_resp_data, 32'h0);
      chk("rst_dm_resp_data", dm_resp_data, 32'h0);
      chk("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
      rst_n = 1'b1;
      tick();

      // Store ack (streak goes to 1)
      dm_req_valid = 1'b1; dm_req_write = 1'b1; dm_req_addr = 32'h100;
      dm_req_wdata = 32'hDEADBEEF; dm_req_wmask = 4'hF; mem_req_ready = 1'b1;
      #1;
      chk("st_mem_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("st_mem_write", {31'h0, mem_req_write}, 32'h1);
      chk("st_mem_addr", mem_req_addr, 32'h100);
      chk("st_mem_wdata", mem_req_wdata, 32'hDEADBEEF);
      chk("st_mem_wmask", {28'h0, mem_req_wmask}, 32'hF);
      chk("st_dm_ready", {31'h0, dm_req_ready}, 32'h1);
      chk("st_if_ready", {31'h0, if_req_ready}, 32'h0);
      tick();
      dm_req_valid = 1'b0; dm_req_write = 1'b0;
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE0001;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      chk("st_dm_resp_valid", {31'h0, dm_resp_valid}, 32'h1);
      chk("st_dm_resp_data", dm_resp_data, 32'h0);

      // Single fetch (streak clears)
      tick();
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      #1;
      chk("f_mem_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("f_mem_addr", mem_req_addr, 32'h10);
      chk("f_mem_write", {31'h0, mem_req_write}, 32'h0);
      chk("f_mem_wmask", {28'h0, mem_req_wmask}, 32'h0);
      chk("f_if_ready", {31'h0, if_req_ready}, 32'h1);
      tick();
      if_req_valid = 1'b0;
      #1;
      chk("f_wait_mem_valid", {31'h0, mem_req_valid}, 32'h0);
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h93;
      #1;
      chk("f_resp_not_early", {31'h0, if_resp_valid}, 32'h0);
      tick();
      mem_resp_valid = 1'b0;
      #1;
      chk("f_if_resp_valid", {31'h0, if_resp_valid}, 32'h1);
      chk("f_if_resp_data", if_resp_data, 32'h93);
      chk("f_dm_resp_valid", {31'h0, dm_resp_valid}, 32'h0);
      tick();
      chk("f_if_resp_pulse", {31'h0, if_resp_valid}, 32'h0);

      // Priority and starvation bound
      if_req_valid = 1'b1; if_req_addr = 32'h200;
      dm_req_valid = 1'b1; dm_req_write = 1'b0; dm_req_addr = 32'h300;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("pr%0d_addr", k), mem_req_addr, exp_dm_order[k] ? 32'h300 : 32'h200);
         chk($sformatf("pr%0d_dm_ready", k), {31'h0, dm_req_ready}, {31'h0, exp_dm_order[k]});
         chk($sformatf("pr%0d_if_ready", k), {31'h0, if_req_ready}, {31'h0, ~exp_dm_order[k]});
         tick();
         mem_resp_valid = 1'b1; mem_resp_data = 32'h50 + 32'(k);
         #1;
         chk($sformatf("pr%0d_wait_valid", k), {31'h0, mem_req_valid}, 32'h0);
         tick();
         mem_resp_valid = 1'b0;
         if (exp_dm_order[k]) begin
            chk($sformatf("pr%0d_dm_resp", k), {31'h0, dm_resp_valid}, 32'h1);
            chk($sformatf("pr%0d_dm_data", k), dm_resp_data, 32'h50 + 32'(k));
         end else begin
            chk($sformatf("pr%0d_if_resp", k), {31'h0, if_resp_valid}, 32'h1);
            chk($sformatf("pr%0d_if_data", k), if_resp_data, 32'h50 + 32'(k));
         end
      end
      if_req_valid = 1'b0; dm_req_valid = 1'b0;
      tick();

      // Grant lock: fetch stalls, data arrives, fetch still goes first
      if_req_valid = 1'b1; if_req_addr = 32'h400; mem_req_ready = 1'b0;
      #1;
      chk("lk_c1_addr", mem_req_addr, 32'h400);
      chk("lk_c1_if_ready", {31'h0, if_req_ready}, 32'h0);
      tick();
      dm_req_valid = 1'b1; dm_req_addr = 32'h500;
      #1;
      chk("lk_c2_addr", mem_req_addr, 32'h400);
      chk("lk_c2_dm_ready", {31'h0, dm_req_ready}, 32'h0);
      tick();
      #1;
      chk("lk_c3_addr", mem_req_addr, 32'h400);
      tick();
      mem_req_ready = 1'b1;
      #1;
      chk("lk_c4_addr", mem_req_addr, 32'h400);
      chk("lk_c4_if_ready", {31'h0, if_req_ready}, 32'h1);
      chk("lk_c4_dm_ready", {31'h0, dm_req_ready}, 32'h0);
      tick();
      if_req_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      chk("lk_if_resp", {31'h0, if_resp_valid}, 32'h1);
      chk("lk_if_data", if_resp_data, 32'h77);
      chk("lk_dm_addr", mem_req_addr, 32'h500);
      chk("lk_dm_ready", {31'h0, dm_req_ready}, 32'h1);
      tick();
      dm_req_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h88;
      tick();
      mem_resp_valid = 1'b0;
      chk("lk_dm_resp", {31'h0, dm_resp_valid}, 32'h1);
      chk("lk_dm_data", dm_resp_data, 32'h88);

      // Reset while a data read is outstanding
      tick();
      dm_req_valid = 1'b1; dm_req_addr = 32'h600;
      tick();
      dm_req_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
      tick();
      mem_resp_valid = 1'b0;
      chk("rm_dm_resp", {31'h0, dm_resp_valid}, 32'h0);
      chk("rm_if_resp", {31'h0, if_resp_valid}, 32'h0);
      chk("rm_dm_data", dm_resp_data, 32'h0);
      tick();
      chk("rm_dm_resp_late", {31'h0, dm_resp_valid}, 32'h0);
      if_req_valid = 1'b1; if_req_addr = 32'h700;
      #1;
      chk("rm_f_mem_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("rm_f_if_ready", {31'h0, if_req_ready}, 32'h1);
      tick();
      if_req_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'hAB;
      tick();
      mem_resp_valid = 1'b0;
      chk("rm_f_resp", {31'h0, if_resp_valid}, 32'h1);
      chk("rm_f_data", if_resp_data, 32'hAB);

      // Spurious response in IDLE
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h1234;
      tick();
      mem_resp_valid = 1'b0;
      chk("sp_if_resp", {31'h0, if_resp_valid}, 32'h0);
      chk("sp_dm_resp", {31'h0, dm_resp_valid}, 32'h0);
      chk("sp_if_data", if_resp_data, 32'hAB);
      chk("sp_dm_data", dm_resp_data, 32'h0);
      chk("sp_mem_valid", {31'h0, mem_req_valid}, 32'h0);
      tick();
      chk("sp_if_resp_late", {31'h0, if_resp_valid}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
